turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Upstream arbiter feeding both tank movement blocks; owns the turn-based game flow.
- Drives player1flag/player2flag, which gate tank motion and the fuel reload.
- Issues one-cycle fire strobes to the bullet block, waits for the shot to resolve, and applies hits to per-player health.
- Ends the game when a tank's health reaches zero.

Parameters:
FIRE_KEY, 8'h2C, keycode that fires the active player's shot (space)
TURN_FRAMES, 10'd600, frames allowed per move phase before the turn passes automatically
FLIGHT_MAX, 10'd255, watchdog: maximum frames a shot may stay unresolved
MAX_HP, 3'd3, starting health per player

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  8  current keyboard code; 8'h00 means no key
shot_done  in  1  bullet block: shot resolved this frame (landed, off-screen or hit)
hit_tank1  in  1  the resolved shot struck tank 1; valid only with shot_done
hit_tank2  in  1  the resolved shot struck tank 2; valid only with shot_done
player1flag  out  1  tank 1 may move and fire
player2flag  out  1  tank 2 may move and fire
fire1  out  1  one-cycle strobe: tank 1 fires
fire2  out  1  one-cycle strobe: tank 2 fires
turn_timer  out  10  frames remaining in the current move phase
p1_health  out  3  tank 1 health
p2_health  out  3  tank 2 health
game_over  out  1  high once the game has ended
winner  out  2  01 = P1 wins, 10 = P2 wins, 11 = draw, 00 = game in progress

Behaviour:
- State machine states: P1_MOVE, P1_FLIGHT, P2_MOVE, P2_FLIGHT, GAME_OVER.
- Reset values (asynchronous):
  - state P1_MOVE; player1flag=1, player2flag=0
  - fire1=fire2=0; turn_timer=TURN_FRAMES
  - p1_health=p2_health=MAX_HP
  - game_over=0, winner=00
  - fire arm bit=0, flight counter=0
- Fire arming:
  - The arm bit sets on any frame where keycode!=FIRE_KEY.
  - A fire event requires keycode==FIRE_KEY with the arm bit set; the arm bit then clears.
  - Holding the key therefore gives exactly one shot. A key held through reset does not fire.
- Output flags are registered and follow the state:
  - P1_MOVE: player1flag=1.
  - P2_MOVE: player2flag=1.
  - All other states: both flags 0, which freezes both tanks during flight and after game over.
- PN_MOVE:
  - turn_timer decrements by 1 each frame.
  - Fire event: fireN=1 for exactly one cycle, go to PN_FLIGHT, flight counter cleared.
  - turn_timer==0 with no fire event: go to the other player's MOVE, no strobe, turn_timer reloads to TURN_FRAMES.
  - Fire event in the same frame as turn_timer==0: the fire event wins.
- PN_FLIGHT:
  - turn_timer holds. The flight counter increments each frame.
  - On shot_done:
    - p1_health decrements by 1 if hit_tank1 is set; p2_health decrements by 1 if hit_tank2 is set.
    - Both hits may be set in the same frame, and a self-hit counts.
    - Health saturates at 0.
    - If either post-decrement health is 0, go to GAME_OVER. Otherwise go to the other player's MOVE with turn_timer=TURN_FRAMES.
  - Flight counter reaches FLIGHT_MAX without shot_done: treat as shot_done with no hits.
- shot_done and the hit inputs are ignored in MOVE and GAME_OVER.
- Keycode is ignored in FLIGHT and GAME_OVER, but the arm bit still updates in those states.
- GAME_OVER:
  - game_over=1; winner set from the final health values (both 0 gives 11).
  - Absorbing state; only Reset leaves it.
- Reset mid-flight or mid-turn: immediate return to the reset values; any pending strobe is dropped.
- Widths: turn_timer and flight counter are 10-bit unsigned. Health is 3-bit unsigned. No wrap is possible because all decrements are guarded.

Test Plan:
1. Reset, then keycode=8'h2C for 1 frame → fire1 high exactly 1 cycle; player1flag=0 the next frame; state P1_FLIGHT.
2. In P1_FLIGHT, shot_done=1 with hit_tank2=1 → p2_health 3→2; player2flag=1; turn_timer=600.
3. Hold FIRE_KEY for 50 frames in P1_MOVE → single fire1 pulse; after resolution to P2_MOVE, no fire2 until the key is released and re-pressed.
4. Idle in P2_MOVE for 600 frames → turn_timer reaches 0 and the next frame player1flag=1 with turn_timer=600; fire2 is never asserted.
5. Fire, then withhold shot_done for 255 frames → turn passes to the other player; health unchanged.
6. p1_health=p2_health=1, shot_done with hit_tank1=hit_tank2=1 → game_over=1, winner=11, both flags 0; later fire keys are ignored; Reset restores health to 3 and player1flag=1.

Source files
------------

// File: rtl/turn_controller_if.sv
// Signal bundle between the turn controller and the tank, bullet and keyboard blocks.
// The master side is the controller; the slave side is its environment.
interface turn_controller_if;
  logic [7:0] keycode;
  logic       shot_done;
  logic       hit_tank1;
  logic       hit_tank2;
  logic       player1flag;
  logic       player2flag;
  logic       fire1;
  logic       fire2;
  logic [9:0] turn_timer;
  logic [2:0] p1_health;
  logic [2:0] p2_health;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    input  keycode, shot_done, hit_tank1, hit_tank2,
    output player1flag, player2flag, fire1, fire2, turn_timer,
           p1_health, p2_health, game_over, winner
  );

  modport slave (
    output keycode, shot_done, hit_tank1, hit_tank2,
    input  player1flag, player2flag, fire1, fire2, turn_timer,
           p1_health, p2_health, game_over, winner
  );
endinterface

// File: rtl/turn_controller.sv
// Turn-based game flow for two tanks: move phases, shot flight, health and game end.
// All outputs are registered and update on the rising frame clock.
module turn_controller #(
  parameter logic [7:0] FIRE_KEY    = 8'h2C,
  parameter logic [9:0] TURN_FRAMES = 10'd600,
  parameter logic [9:0] FLIGHT_MAX  = 10'd255,
  parameter logic [2:0] MAX_HP      = 3'd3
) (
  input  logic               frame_clk,
  input  logic               Reset,
  turn_controller_if.master  tc
);

  typedef enum logic [2:0] {
    P1_MOVE   = 3'd0,
    P1_FLIGHT = 3'd1,
    P2_MOVE   = 3'd2,
    P2_FLIGHT = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [9:0] timer_r, timer_s;
  logic [9:0] flight_cnt_r, flight_cnt_s;
  logic [2:0] p1_hp_r, p1_hp_s;
  logic [2:0] p2_hp_r, p2_hp_s;
  logic       arm_r, arm_s;
  logic       fire1_r, fire1_s;
  logic       fire2_r, fire2_s;
  logic       p1_flag_r, p1_flag_s;
  logic       p2_flag_r, p2_flag_s;
  logic       game_over_r, game_over_s;
  logic [1:0] winner_r, winner_s;
  logic       key_fire_s, fire_ev_s, resolve_s, hit1_s, hit2_s;
  state_t     other_move_s;

  // Next-state and next-output computation for the game flow.
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    flight_cnt_s = flight_cnt_r;
    p1_hp_s      = p1_hp_r;
    p2_hp_s      = p2_hp_r;
    fire1_s      = 1'b0;
    fire2_s      = 1'b0;
    game_over_s  = game_over_r;
    winner_s     = winner_r;
    resolve_s    = 1'b0;
    hit1_s       = 1'b0;
    hit2_s       = 1'b0;
    other_move_s = P1_MOVE;

    key_fire_s = (tc.keycode == FIRE_KEY);
    fire_ev_s  = key_fire_s && arm_r && ((state_r == P1_MOVE) || (state_r == P2_MOVE));

    // A press is consumed only by an actual shot; releasing re-arms.
    if (!key_fire_s) begin
      arm_s = 1'b1;
    end else if (fire_ev_s) begin
      arm_s = 1'b0;
    end else begin
      arm_s = arm_r;
    end

    case (state_r)
      P1_MOVE, P2_MOVE: begin
        if (timer_r != 10'd0) begin
          timer_s = timer_r - 10'd1;
        end else begin
          timer_s = timer_r;
        end
        if (fire_ev_s) begin
          fire1_s      = (state_r == P1_MOVE);
          fire2_s      = (state_r == P2_MOVE);
          state_s      = (state_r == P1_MOVE) ? P1_FLIGHT : P2_FLIGHT;
          flight_cnt_s = 10'd0;
        end else if (timer_r == 10'd0) begin
          state_s = (state_r == P1_MOVE) ? P2_MOVE : P1_MOVE;
          timer_s = TURN_FRAMES;
        end else begin
          state_s = state_r;
        end
      end
      P1_FLIGHT, P2_FLIGHT: begin
        flight_cnt_s = flight_cnt_r + 10'd1;
        other_move_s = (state_r == P1_FLIGHT) ? P2_MOVE : P1_MOVE;
        if (tc.shot_done) begin
          resolve_s = 1'b1;
          hit1_s    = tc.hit_tank1;
          hit2_s    = tc.hit_tank2;
        end else if (flight_cnt_s == FLIGHT_MAX) begin
          resolve_s = 1'b1;
        end else begin
          resolve_s = 1'b0;
        end
      end
      GAME_OVER: begin
        state_s = GAME_OVER;
      end
      default: begin
        state_s = P1_MOVE;
      end
    endcase

    // Shot resolution: saturating damage, then either game end or turn handover.
    if (resolve_s) begin
      if (hit1_s && (p1_hp_r != 3'd0)) begin
        p1_hp_s = p1_hp_r - 3'd1;
      end else begin
        p1_hp_s = p1_hp_r;
      end
      if (hit2_s && (p2_hp_r != 3'd0)) begin
        p2_hp_s = p2_hp_r - 3'd1;
      end else begin
        p2_hp_s = p2_hp_r;
      end
      if ((p1_hp_s == 3'd0) || (p2_hp_s == 3'd0)) begin
        state_s     = GAME_OVER;
        game_over_s = 1'b1;
        if ((p1_hp_s == 3'd0) && (p2_hp_s == 3'd0)) begin
          winner_s = 2'b11;
        end else if (p2_hp_s == 3'd0) begin
          winner_s = 2'b01;
        end else begin
          winner_s = 2'b10;
        end
      end else begin
        state_s = other_move_s;
        timer_s = TURN_FRAMES;
      end
    end else begin
      p1_hp_s = p1_hp_r;
      p2_hp_s = p2_hp_r;
    end

    p1_flag_s = (state_s == P1_MOVE);
    p2_flag_s = (state_s == P2_MOVE);
  end

  // State and output registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r      <= P1_MOVE;
      timer_r      <= TURN_FRAMES;
      flight_cnt_r <= 10'd0;
      p1_hp_r      <= MAX_HP;
      p2_hp_r      <= MAX_HP;
      arm_r        <= 1'b0;
      fire1_r      <= 1'b0;
      fire2_r      <= 1'b0;
      p1_flag_r    <= 1'b1;
      p2_flag_r    <= 1'b0;
      game_over_r  <= 1'b0;
      winner_r     <= 2'b00;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      flight_cnt_r <= flight_cnt_s;
      p1_hp_r      <= p1_hp_s;
      p2_hp_r      <= p2_hp_s;
      arm_r        <= arm_s;
      fire1_r      <= fire1_s;
      fire2_r      <= fire2_s;
      p1_flag_r    <= p1_flag_s;
      p2_flag_r    <= p2_flag_s;
      game_over_r  <= game_over_s;
      winner_r     <= winner_s;
    end
  end

  assign tc.player1flag = p1_flag_r;
  assign tc.player2flag = p2_flag_r;
  assign tc.fire1       = fire1_r;
  assign tc.fire2       = fire2_r;
  assign tc.turn_timer  = timer_r;
  assign tc.p1_health   = p1_hp_r;
  assign tc.p2_health   = p2_hp_r;
  assign tc.game_over   = game_over_r;
  assign tc.winner      = winner_r;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized and directed bench for turn_controller against a frame-level game model.
module tb_turn_controller;
  logic frame_clk = 1'b0;
  logic Reset;

  turn_controller_if tc_if();

  turn_controller dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .tc        (tc_if.master)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: whose turn, whether a shot is airborne, and the visible results.
  int m_player, m_timer, m_fly, m_hp1, m_hp2, m_winner;
  bit m_flying, m_over, m_armed, m_fire1, m_fire2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_player = 1; m_flying = 0; m_over = 0; m_timer = 600; m_fly = 0;
    m_hp1 = 3; m_hp2 = 3; m_armed = 0; m_fire1 = 0; m_fire2 = 0; m_winner = 0;
  endtask

  task automatic model_step(input logic [7:0] key, input bit sd, input bit h1, input bit h2);
    bit pressed, can_fire, new_armed;
    int old_timer;
    pressed   = (key == 8'h2C);
    can_fire  = !m_over && !m_flying && pressed && m_armed;
    new_armed = !pressed ? 1'b1 : (can_fire ? 1'b0 : m_armed);
    m_fire1 = 0;
    m_fire2 = 0;
    if (m_over) begin
      // nothing changes after the game has ended
    end else if (!m_flying) begin
      old_timer = m_timer;
      if (m_timer > 0) m_timer--;
      if (can_fire) begin
        if (m_player == 1) m_fire1 = 1; else m_fire2 = 1;
        m_flying = 1;
        m_fly = 0;
      end else if (old_timer == 0) begin
        m_player = 3 - m_player;
        m_timer = 600;
      end
    end else begin
      m_fly++;
      if (sd || m_fly == 255) begin
        if (sd && h1 && m_hp1 > 0) m_hp1--;
        if (sd && h2 && m_hp2 > 0) m_hp2--;
        if (m_hp1 == 0 || m_hp2 == 0) begin
          m_over = 1;
          m_flying = 0;
          if (m_hp1 == 0 && m_hp2 == 0) m_winner = 3;
          else if (m_hp2 == 0) m_winner = 1;
          else m_winner = 2;
        end else begin
          m_flying = 0;
          m_player = 3 - m_player;
          m_timer = 600;
        end
      end
    end
    m_armed = new_armed;
  endtask

  task automatic compare_all(input string ph);
    check_val({ph, ".p1flag"}, 32'(tc_if.player1flag), 32'(!m_over && !m_flying && m_player == 1));
    check_val({ph, ".p2flag"}, 32'(tc_if.player2flag), 32'(!m_over && !m_flying && m_player == 2));
    check_val({ph, ".fire1"},  32'(tc_if.fire1), 32'(m_fire1));
    check_val({ph, ".fire2"},  32'(tc_if.fire2), 32'(m_fire2));
    check_val({ph, ".timer"},  32'(tc_if.turn_timer), 32'(m_timer));
    check_val({ph, ".hp1"},    32'(tc_if.p1_health), 32'(m_hp1));
    check_val({ph, ".hp2"},    32'(tc_if.p2_health), 32'(m_hp2));
    check_val({ph, ".over"},   32'(tc_if.game_over), 32'(m_over));
    check_val({ph, ".winner"}, 32'(tc_if.winner), 32'(m_winner));
  endtask

  task automatic frame(input logic [7:0] key, input bit sd, input bit h1, input bit h2);
    tc_if.keycode   = key;
    tc_if.shot_done = sd;
    tc_if.hit_tank1 = h1;
    tc_if.hit_tank2 = h2;
    @(posedge frame_clk);
    model_step(key, sd, h1, h2);
    #1;
    compare_all("frame");
  endtask

  // Asserts Reset between edges, checks the asynchronous effect, holds for one edge.
  task automatic do_reset();
    Reset = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    @(posedge frame_clk);
    #1;
    compare_all("reset_hold");
    Reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int r;
    logic [7:0] k;
    Reset = 1'b1;
    tc_if.keycode = 8'h2C;
    tc_if.shot_done = 1'b0;
    tc_if.hit_tank1 = 1'b0;
    tc_if.hit_tank2 = 1'b0;
    #2;
    model_reset();
    compare_all("por");
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // Key held through reset must not fire; a fresh press fires tank 1 once.
    frame(8'h2C, 0, 0, 0);
    check_val("held_through_reset_fire1", 32'(tc_if.fire1), 32'd0);
    frame(8'h00, 0, 0, 0);
    frame(8'h2C, 0, 0, 0);
    check_val("t1_fire1", 32'(tc_if.fire1), 32'd1);
    check_val("t1_p1flag", 32'(tc_if.player1flag), 32'd0);
    frame(8'h00, 0, 0, 0);
    check_val("t1_fire1_once", 32'(tc_if.fire1), 32'd0);
    for (int i = 0; i < 5; i++) frame(8'h00, 0, 0, 0);

    // Hit on tank 2 hands the turn over with a fresh timer.
    frame(8'h00, 1, 0, 1);
    check_val("t2_hp2", 32'(tc_if.p2_health), 32'd2);
    check_val("t2_p2flag", 32'(tc_if.player2flag), 32'd1);
    check_val("t2_timer", 32'(tc_if.turn_timer), 32'd600);

    // Holding the key across a turn handover yields exactly one shot.
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      frame(8'h2C, (i == 20), 0, 0);
      pulses += int'(tc_if.fire1) + int'(tc_if.fire2);
    end
    check_val("t3_single_pulse", 32'(pulses), 32'd1);
    check_val("t3_p1flag", 32'(tc_if.player1flag), 32'd1);
    frame(8'h00, 0, 0, 0);
    frame(8'h2C, 0, 0, 0);
    check_val("t3_refire", 32'(tc_if.fire1), 32'd1);
    frame(8'h00, 1, 0, 0);

    // Idle turn: timer runs down to zero, then the turn passes.
    for (int i = 0; i < 600; i++) frame(8'h00, 0, 0, 0);
    check_val("t4_timer_zero", 32'(tc_if.turn_timer), 32'd0);
    frame(8'h00, 0, 0, 0);
    check_val("t4_p1flag", 32'(tc_if.player1flag), 32'd1);
    check_val("t4_timer_reload", 32'(tc_if.turn_timer), 32'd600);

    // Unresolved shot times out after the flight limit.
    frame(8'h2C, 0, 0, 0);
    for (int i = 0; i < 254; i++) frame(8'h00, 0, 0, 0);
    check_val("t5_still_flying", 32'(tc_if.player2flag), 32'd0);
    frame(8'h00, 0, 0, 0);
    check_val("t5_p2flag", 32'(tc_if.player2flag), 32'd1);
    check_val("t5_hp1", 32'(tc_if.p1_health), 32'd3);
    check_val("t5_hp2", 32'(tc_if.p2_health), 32'd2);

    // Mutual hits down to zero give a draw; the end state is absorbing.
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      frame(8'h00, 0, 0, 0);
      frame(8'h2C, 0, 0, 0);
      frame(8'h00, 0, 0, 0);
      frame(8'h00, 1, 1, 1);
    end
    check_val("t6_over", 32'(tc_if.game_over), 32'd1);
    check_val("t6_draw", 32'(tc_if.winner), 32'd3);
    check_val("t6_flags", 32'({tc_if.player1flag, tc_if.player2flag}), 32'd0);
    for (int i = 0; i < 10; i++) frame((i % 2 == 0) ? 8'h2C : 8'h00, 1, 1, 1);
    do_reset();
    check_val("t6_hp_restored", 32'(tc_if.p1_health), 32'd3);
    check_val("t6_p1flag", 32'(tc_if.player1flag), 32'd1);

    // Reset while the fire strobe is high drops it.
    frame(8'h00, 0, 0, 0);
    frame(8'h2C, 0, 0, 0);
    do_reset();
    check_val("midflight_fire_dropped", 32'(tc_if.fire1), 32'd0);

    // Randomized play with occasional resets.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 3);
        if (r == 0) k = 8'h00;
        else if (r == 3) k = 8'($urandom_range(0, 255));
        else k = 8'h2C;
        frame(k, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
